// File: rtl/mem_stage_ls.sv
// MEM pipeline stage with req/ack data-memory handshake, wait-state
// timeout, byte-lane store steering and load sign/zero extension.
module mem_stage_ls #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WAIT_LIMIT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_mem,
  input  logic [XLEN-1:0]           pc_mem,
  input  logic [XLEN-1:0]           instr_mem,
  input  logic [XLEN-1:0]           alu_mem,
  input  logic [XLEN-1:0]           rs2_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [2:0]                funct3_mem,
  input  logic                      flush,
  output logic                      stall_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      valid_wb,
  output logic [XLEN-1:0]           pc_wb,
  output logic [XLEN-1:0]           instr_wb,
  output logic [XLEN-1:0]           alu_wb,
  output logic [XLEN-1:0]           mem_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
  output logic                      misalign_wb,
  output logic                      buserr_wb
);

  localparam int            CW    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            flush_pending;

  logic [1:0]      lane, size;
  logic            mem_op, misaligned, live, access;
  logic            in_idle, in_wait, below, killed;
  logic [3:0]      be_st;
  logic [XLEN-1:0] shifted, ld_ext, mem_res;

  assign lane       = alu_mem[1:0];
  assign size       = funct3_mem[1:0];
  assign mem_op     = mem_rd | mem_wr;
  assign misaligned = ((size == 2'b01) & lane[0]) | ((size == 2'b10) & (lane != 2'b00));
  assign live       = valid_mem & ~flush;
  assign access     = live & mem_op & ~misaligned;
  assign in_idle    = (state == S_IDLE);
  assign in_wait    = (state == S_WAIT);
  assign below      = (cnt < LIMIT);
  assign killed     = flush | flush_pending;

  // Request and stall are forced low while reset is held so an abort is immediate
  assign dmem_req  = ~rst & ((in_idle & access) | in_wait);
  assign stall_out = ~rst & ((in_idle & access & ~dmem_ack) | (in_wait & ~dmem_ack & below));
  assign dmem_we   = mem_wr;
  assign dmem_addr = {alu_mem[XLEN-1:2], 2'b00};

  // Store data replicated into every byte lane; byte enables pick the live ones
  for (genvar i = 0; i < XLEN/8; i++) begin : g_lane
    assign dmem_wdata[8*i +: 8] = (size == 2'b00) ? rs2_mem[7:0] :
                                  (size == 2'b01) ? rs2_mem[8*(i%2) +: 8] :
                                                    rs2_mem[8*i +: 8];
  end

  // Byte enables: shifted by lane for sub-word stores, full word for loads
  always_comb begin
    be_st = 4'hF;
    case (size)
      2'b00:   be_st = 4'b0001 << lane;
      2'b01:   be_st = 4'b0011 << lane;
      default: be_st = 4'hF;
    endcase
    dmem_be = mem_wr ? be_st : 4'hF;
  end

  // Load extraction and extension from the addressed lane
  assign shifted = dmem_rdata >> {lane, 3'b000};
  always_comb begin
    ld_ext = dmem_rdata;
    case (funct3_mem)
      3'b000:  ld_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
      default: ld_ext = dmem_rdata;
    endcase
  end
  assign mem_res = mem_rd ? ld_ext : '0;

  // Handshake FSM and MEM/WB register; default each cycle is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      flush_pending <= 1'b0;
      valid_wb      <= 1'b0;
      pc_wb         <= '0;
      instr_wb      <= '0;
      alu_wb        <= '0;
      mem_wb        <= '0;
      rd_addr_wb    <= '0;
      misalign_wb   <= 1'b0;
      buserr_wb     <= 1'b0;
    end else begin
      valid_wb    <= 1'b0;
      rd_addr_wb  <= '0;
      misalign_wb <= 1'b0;
      buserr_wb   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (dmem_ack) begin
              valid_wb   <= 1'b1;
              pc_wb      <= pc_mem;
              instr_wb   <= instr_mem;
              alu_wb     <= alu_mem;
              mem_wb     <= mem_res;
              rd_addr_wb <= rd_addr_mem;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(1);
            end
          end else if (live) begin
            // Non-memory pass-through, or misaligned access trapped without a request
            valid_wb <= 1'b1;
            pc_wb    <= pc_mem;
            instr_wb <= instr_mem;
            alu_wb   <= alu_mem;
            mem_wb   <= '0;
            if (mem_op) misalign_wb <= 1'b1;
            else        rd_addr_wb  <= rd_addr_mem;
          end
        end
        S_WAIT: begin
          if (dmem_ack || !below) begin
            // Completion or timeout; a flush seen during the wait kills the result
            state         <= S_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            valid_wb      <= ~killed;
            pc_wb         <= pc_mem;
            instr_wb      <= instr_mem;
            alu_wb        <= alu_mem;
            if (dmem_ack) begin
              mem_wb     <= mem_res;
              rd_addr_wb <= killed ? '0 : rd_addr_mem;
            end else begin
              mem_wb    <= '0;
              buserr_wb <= ~killed;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (flush) flush_pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
